// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: access size codes,
// FSM state encoding, lane widths and the alignment helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        TamDouble = 2'b00,
        TamWord   = 2'b01,
        TamHalf   = 2'b10,
        TamByte   = 2'b11
    } tam_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCap,
        StWr,
        StDone,
        StErr
    } state_e;

    localparam int unsigned DwordBits = 64;
    localparam int unsigned WordBits  = 32;
    localparam int unsigned HalfBits  = 16;
    localparam int unsigned ByteBits  = 8;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(tam_e tam, logic [2:0] off);
        logic mis;
        mis = 1'b0;
        unique case (tam)
            TamDouble: mis = |off;
            TamWord:   mis = |off[1:0];
            TamHalf:   mis = off[0];
            TamByte:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clears the offset bits that lie inside the access size.
    function automatic logic [2:0] align_offset(tam_e tam, logic [2:0] off);
        logic [2:0] res;
        res = off;
        unique case (tam)
            TamDouble: res = 3'b000;
            TamWord:   res = {off[2], 2'b00};
            TamHalf:   res = {off[2:1], 1'b0};
            TamByte:   res = off;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Control-unit and memory-side signals of the data-memory responder.
// slave: responder view; master: control unit plus memory view.
interface dmem_if
    import dmem_pkg::*;
();
    logic        req;
    logic        we;
    tam_e        tam;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        done;
    logic        busy;
    logic        misaligned;
    logic [63:0] mem_addr;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req, we, tam, addr, wdata, mem_rdata,
        output rdata, done, busy, misaligned, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output req, we, tam, addr, wdata, mem_rdata,
        input  rdata, done, busy, misaligned, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/dmem_lane_merge.sv
// Combinational lane logic: extracts and sign-extends the addressed lane of a
// doubleword for loads, and splices store data into that lane for stores.
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  tam_e        tam_i,
    input  logic [2:0]  offset_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] merged_o
);

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] lane_mask;

    // Lane extract with sign extension, and read-modify-write merge.
    always_comb begin
        shamt       = {offset_i, 3'b000};
        shifted     = rdata_i >> shamt;
        load_data_o = shifted;
        lane_mask   = '1;
        unique case (tam_i)
            TamDouble: begin
                load_data_o = shifted;
                lane_mask   = '1;
            end
            TamWord: begin
                load_data_o = {{(DwordBits - WordBits){shifted[WordBits-1]}},
                               shifted[WordBits-1:0]};
                lane_mask   = {{(DwordBits - WordBits){1'b0}}, {WordBits{1'b1}}};
            end
            TamHalf: begin
                load_data_o = {{(DwordBits - HalfBits){shifted[HalfBits-1]}},
                               shifted[HalfBits-1:0]};
                lane_mask   = {{(DwordBits - HalfBits){1'b0}}, {HalfBits{1'b1}}};
            end
            TamByte: begin
                load_data_o = {{(DwordBits - ByteBits){shifted[ByteBits-1]}},
                               shifted[ByteBits-1:0]};
                lane_mask   = {{(DwordBits - ByteBits){1'b0}}, {ByteBits{1'b1}}};
            end
        endcase
        merged_o = (rdata_i & ~(lane_mask << shamt)) | ((wdata_i & lane_mask) << shamt);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one load/store at a time from the control unit
// against a doubleword memory with one cycle of read latency. Sub-doubleword
// stores are read-modify-write. Misalignment rejection is built only when
// DMEM_MISALIGN_CHECK_EN is defined; otherwise low offset bits are ignored.
module dmem_responder
    import dmem_pkg::*;
(
    input  logic    clk,
    input  logic    Reset,
    dmem_if.slave   bus
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    tam_e        tam_q, tam_d;
    logic [2:0]  offset_q, offset_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;

    logic        req_mis;
    logic [2:0]  req_offset;
    logic [63:0] load_data;
    logic [63:0] merged;

    // Request-time alignment decision and effective lane offset.
    always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
        req_mis    = is_misaligned(bus.tam, bus.addr[2:0]);
        req_offset = bus.addr[2:0];
`else
        req_mis    = 1'b0;
        req_offset = align_offset(bus.tam, bus.addr[2:0]);
`endif
    end

    dmem_lane_merge u_lane_merge (
        .tam_i       (tam_q),
        .offset_i    (offset_q),
        .rdata_i     (bus.mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    // Next-state and datapath updates for the access FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        tam_d       = tam_q;
        offset_d    = offset_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (bus.req) begin
                    we_d       = bus.we;
                    tam_d      = bus.tam;
                    offset_d   = req_offset;
                    wdata_d    = bus.wdata;
                    mem_addr_d = {bus.addr[63:3], 3'b000};
                    if (req_mis) begin
                        state_d = StErr;
                    end else if (bus.we && (bus.tam == TamDouble)) begin
                        // Full-width store needs no read; write straight away.
                        mem_wdata_d = bus.wdata;
                        state_d     = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StCap;
            StCap: begin
                if (we_q) begin
                    mem_wdata_d = merged;
                    state_d     = StWr;
                end else begin
                    rdata_d = load_data;
                    state_d = StDone;
                end
            end
            StWr:   state_d = StDone;
            StDone: state_d = StIdle;
            StErr:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously by Reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            tam_q       <= TamDouble;
            offset_q    <= 3'b000;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            tam_q       <= tam_d;
            offset_q    <= offset_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Status outputs decode from the state register so Reset drops them at once.
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone) || (state_q == StErr);
    assign bus.mem_wr    = (state_q == StWr);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign bus.misaligned = (state_q == StErr);
`else
    assign bus.misaligned = 1'b0;
`endif
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized accesses checked
// against a byte-level reference model of memory and the load register.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk;
    logic Reset;

    dmem_if bus ();

    dmem_responder u_dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one cycle read latency, bench preload port.
    logic [63:0] mem [0:63];
    logic [63:0] ref_mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [63:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_wr) mem[bus.mem_addr[8:3]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[8:3]];
    end

    int          total;
    int          bad;
    int          got_done;
    int          first_wr;
    int          wr_cnt;
    logic        mis_seen;
    int          exp_done;
    int          exp_wr;
    logic        exp_mis;
    logic [63:0] ref_rdata;
    int          n_done;
    logic [63:0] ra;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        pre_we   = 1'b1;
        pre_idx  = a[8:3];
        pre_data = d;
        ref_mem[a[8:3]] = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Reference: size in bytes is 8 >> tam; lanes are little-endian bytes.
    task automatic model(input logic w, input logic [1:0] t, input logic [63:0] a,
                         input logic [63:0] wd);
        int n;
        int off;
        logic [63:0] dw;
        logic [63:0] r;
        n   = 8 >> t;
        off = int'(a[2:0]);
        exp_mis = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_mis = (off % n) != 0;
`else
        off = (off / n) * n;
`endif
        dw = ref_mem[a[8:3]];
        exp_wr = 0;
        if (exp_mis) begin
            exp_done = 1;
        end else if (!w) begin
            r = '0;
            for (int i = 0; i < n; i++) r[8*i +: 8] = dw[8*(off+i) +: 8];
            if (r[8*n-1]) for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
            ref_rdata = r;
            exp_done  = 3;
        end else begin
            for (int i = 0; i < n; i++) dw[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[a[8:3]] = dw;
            exp_wr   = 1;
            exp_done = (n == 8) ? 2 : 4;
        end
    endtask

    // Issue one request at cycle 0 and watch up to 8 cycles for done.
    task automatic run_access(input logic w, input logic [1:0] t, input logic [63:0] a,
                              input logic [63:0] wd);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.tam   = tam_e'(t);
        bus.addr  = a;
        bus.wdata = wd;
        tick();
        bus.req  = 1'b0;
        got_done = -1;
        first_wr = -1;
        wr_cnt   = 0;
        mis_seen = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.mem_wr) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = c;
            end
            if (bus.misaligned) mis_seen = 1'b1;
            if (bus.done) begin
                got_done = c;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic access_checked(input string tag, input logic w, input logic [1:0] t,
                                  input logic [63:0] a, input logic [63:0] wd);
        model(w, t, a, wd);
        run_access(w, t, a, wd);
        check({tag, " done_cycle"}, 64'(got_done), 64'(exp_done));
        check({tag, " misaligned"}, 64'(mis_seen), 64'(exp_mis));
        check({tag, " wr_count"}, 64'(wr_cnt), 64'(exp_wr));
        check({tag, " rdata"}, bus.rdata, ref_rdata);
        check({tag, " memory"}, mem[a[8:3]], ref_mem[a[8:3]]);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        ref_rdata = '0;
        pre_we    = 1'b0;
        pre_idx   = '0;
        pre_data  = '0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.tam   = TamDouble;
        bus.addr  = '0;
        bus.wdata = '0;
        Reset     = 1'b1;
        #1;
        check("reset rdata", bus.rdata, 64'h0);
        check("reset mem_addr", bus.mem_addr, 64'h0);
        check("reset mem_wdata", bus.mem_wdata, 64'h0);
        check("reset flags", {60'h0, bus.done, bus.busy, bus.misaligned, bus.mem_wr}, 64'h0);
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 32; i < 40; i++) preload(64'(i * 8), {$urandom(), $urandom()});
        preload(64'h100, 64'h1122334455667788);

        // Byte loads at both ends of the doubleword.
        access_checked("ld_b_100", 1'b0, 2'b11, 64'h100, 64'h0);
        check("ld_b_100 literal", bus.rdata, 64'hFFFFFFFFFFFFFF88);
        access_checked("ld_b_107", 1'b0, 2'b11, 64'h107, 64'h0);
        check("ld_b_107 literal", bus.rdata, 64'h11);

        // Half store with junk above the low 16 bits.
        access_checked("st_h_102", 1'b1, 2'b10, 64'h102, 64'h12340000_0000ABCD);
        check("st_h_102 literal", mem[32], 64'h11223344ABCD7788);
        check("st_h_102 rdata kept", bus.rdata, 64'h11);

        // Word load at offset 2.
        preload(64'h100, 64'h1122334455667788);
        access_checked("ld_w_102", 1'b0, 2'b01, 64'h102, 64'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("ld_w_102 literal", bus.rdata, 64'h11);
`else
        check("ld_w_102 literal", bus.rdata, 64'h0000000055667788);
`endif

        // Doubleword store writes at cycle 1 without a read.
        access_checked("st_d_100", 1'b1, 2'b00, 64'h100, 64'hDEADBEEF00000000);
        check("st_d_100 first_wr", 64'(first_wr), 64'd1);
        check("st_d_100 literal", mem[32], 64'hDEADBEEF00000000);

        // A second req during a load is dropped.
        model(1'b0, 2'b11, 64'h107, 64'h0);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.tam  = TamByte;
        bus.addr = 64'h107;
        tick();
        bus.addr = 64'h100;
        tick();
        bus.req  = 1'b0;
        n_done   = 0;
        got_done = -1;
        for (int c = 2; c <= 9; c++) begin
            if (bus.done) begin
                n_done++;
                if (got_done < 0) got_done = c;
            end
            tick();
        end
        check("ignored_req done_count", 64'(n_done), 64'd1);
        check("ignored_req done_cycle", 64'(got_done), 64'd3);
        check("ignored_req rdata", bus.rdata, ref_rdata);
        check("ignored_req literal", bus.rdata, 64'hFFFFFFFFFFFFFFDE);

        // Reset while in WR aborts the write.
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.tam   = TamHalf;
        bus.addr  = 64'h108;
        bus.wdata = 64'h5555;
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        check("rst_wr in WR", 64'(bus.mem_wr), 64'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_wr mem_wr", 64'(bus.mem_wr), 64'd0);
        check("rst_wr busy", 64'(bus.busy), 64'd0);
        check("rst_wr done", 64'(bus.done), 64'd0);
        check("rst_wr rdata", bus.rdata, 64'h0);
        ref_rdata = '0;
        tick();
        Reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.done) n_done++;
            tick();
        end
        check("rst_wr no_done", 64'(n_done), 64'd0);
        check("rst_wr memory", mem[33], ref_mem[33]);

        // Randomized accesses within the preloaded window.
        for (int k = 0; k < 40; k++) begin
            ra = 64'h100 + 64'($urandom_range(0, 63));
            access_checked("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra,
                           {$urandom(), $urandom()});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL: Reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL: req  in  1  one-cycle access request from control unit; sampled only in IDLE.
REQ-004 SHALL: we  in  1  1 = store, 0 = load.
REQ-005 SHALL: tam  in  2  access size: 00 doubleword, 01 word, 10 half, 11 byte.
REQ-006 SHALL: addr  in  64  byte address.
REQ-007 SHALL: wdata  in  64  store data, right-justified (low bits used).
REQ-008 SHALL: rdata  out  64  load result, sign-extended to 64 bits; holds until next load completes.
REQ-009 SHALL: done  out  1  one-cycle completion pulse.
REQ-010 SHALL: busy  out  1  high in every state except IDLE.
REQ-011 SHALL: misaligned  out  1  one-cycle pulse coincident with done on a rejected access.
REQ-012 SHALL: mem_addr  out  64  addr with bits [2:0] forced to 0.
REQ-013 SHALL: mem_wr  out  1  memory write strobe.
REQ-014 SHALL: mem_wdata  out  64  merged doubleword to memory.
REQ-015 SHALL: mem_rdata  in  64  memory read data, valid one cycle after mem_addr is driven.

Function
REQ-016 SHALL: implement FSM states IDLE, RD, CAP, WR, DONE, ERR.
REQ-017 SHALL: IDLE + req latch we, tam, addr, wdata and drive mem_addr; then go to ERR if misaligned; else to WR for a doubleword store; else to RD.
REQ-018 SHALL: RD -> CAP unconditionally, with mem_wr = 0.
REQ-019 SHALL: CAP captures mem_rdata.
  - Load: extract the lane at byte offset addr[2:0] (little-endian, byte k = bits [8k+7:8k]), sign-extend into rdata, go to DONE.
  - Store: replace the addressed lane with the low bits of wdata, register the result to mem_wdata, go to WR.
REQ-020 SHALL: WR asserts mem_wr for exactly one cycle, then goes to DONE; a doubleword store drives mem_wdata = wdata.
REQ-021 SHALL: DONE and ERR assert done for one cycle, then return to IDLE; ERR also asserts misaligned.
REQ-022 SHALL: meet these latencies from the req cycle (cycle 0):
  - load: done at cycle 3;
  - sub-doubleword store: done at cycle 4;
  - doubleword store: done at cycle 2;
  - misaligned: done at cycle 1.
REQ-023 SHALL: ignore req while busy = 1, with no queuing.
REQ-024 SHALL: keep rdata unchanged after stores and after misaligned accesses.
REQ-025 SHALL: define misalignment as a nonzero value in addr[2:0], addr[1:0] or addr[0] for doubleword, word and half respectively; byte accesses are never misaligned.

Reset
REQ-026 SHALL: Reset forces IDLE and drives rdata, mem_wdata and mem_addr to 0, and done, busy, misaligned and mem_wr to 0, immediately and independent of clk.
REQ-027 SHALL: Reset during WR abort the write with mem_wr low at once; no done is produced for the aborted access.

Configuration
REQ-028 SHALL: macro DMEM_MISALIGN_CHECK_EN defined enables misalignment detection per REQ-017/REQ-025.
REQ-029 SHALL: with DMEM_MISALIGN_CHECK_EN undefined:
  - ERR is never entered and misaligned is tied 0;
  - the offset is addr[2:0] with the size-alignment bits forced to 0 (word -> addr[2] only, half -> addr[2:1]).

Structure
REQ-030 SHALL: package dmem_pkg holds the tam size encodings, the FSM state enum and lane-width constants.
REQ-031 SHALL: one combinational sub-module dmem_lane_merge performs lane extract/sign-extend and lane merge; the FSM lives in dmem_responder.

Verification
Memory preset: doubleword at 0x100 = 0x1122334455667788.
REQ-032 SHALL: load byte at 0x100 -> rdata = 0xFFFFFFFFFFFFFF88, done at cycle 3; load byte at 0x107 -> rdata = 0x11.
REQ-033 SHALL: store half 0xABCD at 0x102 -> memory = 0x11223344ABCD7788, mem_wr high exactly one cycle, done at cycle 4.
REQ-034 SHALL: store doubleword 0xDEADBEEF00000000 at 0x100 -> mem_wr at cycle 1 with no prior read, done at cycle 2.
REQ-035 SHALL: load word at 0x102:
  - macro on -> done and misaligned at cycle 1, no memory access, rdata unchanged;
  - macro off -> rdata = 0x0000000055667788.
REQ-036 SHALL: second req at cycle 1 of a load -> ignored; Reset asserted in WR -> mem_wr and busy drop at once, memory unchanged.
